// File: rtl/poolb_pkg.sv
// Shared types and sizing helpers for the poolb row feeder and its line buffer.
// The default geometry here mirrors the feeder's default parameters.
package poolb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_IFM_SIZE   = 32;
    localparam int DEF_IFM_DEPTH  = 16;

    // Counter widths for the default geometry.
    localparam int CW = $clog2(DEF_IFM_SIZE);
    localparam int MW = $clog2(DEF_IFM_DEPTH);

    typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } fsm_t;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poolb_line_buf.sv
// One-row line buffer: single write port, single read port with a registered output.
// Only the output register is reset; the storage array is not.
module poolb_line_buf
    import poolb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IFM_SIZE,
    parameter int AW         = cnt_width(DEF_IFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds between reads so data_out_A keeps its value across bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/poolb_row_feeder.sv
// Pairs each odd row with the buffered even row above it and emits the column
// strobes a poolb_unit lane consumes, one pair per valid odd-row pixel.
module poolb_row_feeder
    import poolb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IFM_SIZE    = DEF_IFM_SIZE,
    parameter int IFM_DEPTH   = DEF_IFM_DEPTH,
    parameter int KERNAL_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] data_out_A,
    output logic [DATA_WIDTH-1:0] data_out_B,
    output logic                  fifo_enable,
    output logic                  pool_enable,
    output logic                  map_done,
    output logic                  frame_done
);

    localparam int COL_W = cnt_width(IFM_SIZE);
    localparam int MAP_W = cnt_width(IFM_DEPTH);

    generate
        if (KERNAL_SIZE != 2) begin : g_bad_kernel
            $error("poolb_row_feeder: only KERNAL_SIZE = 2 is supported");
        end
        if ((IFM_SIZE % 2) != 0) begin : g_bad_size
            $error("poolb_row_feeder: IFM_SIZE must be even");
        end
    endgenerate

    fsm_t             state;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] row;
    logic [MAP_W-1:0] map;

    logic last_col;
    logic last_row;
    logic last_map;
    logic wr_en;
    logic rd_en;

    assign last_col = (col == COL_W'(IFM_SIZE - 1));
    assign last_row = (row == COL_W'(IFM_SIZE - 1));
    assign last_map = (map == MAP_W'(IFM_DEPTH - 1));

    // Even rows only write, odd rows only read, so the two ports never collide.
    assign wr_en = in_valid && (state == FILL);
    assign rd_en = in_valid && (state == PAIR);

    poolb_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IFM_SIZE),
        .AW         (COL_W)
    ) u_line_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (col),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (col),
        .rd_data (data_out_A)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FILL;
            col         <= '0;
            row         <= '0;
            map         <= '0;
            data_out_B  <= '0;
            fifo_enable <= 1'b0;
            pool_enable <= 1'b0;
            map_done    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            fifo_enable <= 1'b0;
            pool_enable <= 1'b0;
            map_done    <= 1'b0;
            frame_done  <= 1'b0;

            if (in_valid) begin
                if (state == PAIR) begin
                    data_out_B  <= in_data;
                    fifo_enable <= 1'b1;
                    pool_enable <= col[0];
                    map_done    <= last_col && last_row;
                    frame_done  <= last_col && last_row && last_map;
                end

                if (last_col) begin
                    col   <= '0;
                    state <= (state == FILL) ? PAIR : FILL;
                    if (last_row) begin
                        row <= '0;
                        map <= last_map ? '0 : map + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule
